syn_fifo_lvl: RTL and testbench

Parametrised synchronous FIFO, successor to the basic single-clock FIFO. Adds:
- fill-level count output
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- synchronous flush
- selectable read mode: first-word-fall-through, or registered read with valid strobe

Used as the general-purpose buffering primitive between single-clock pipeline stages.

---
 rtl/syn_fifo_lvl.sv | 110 +++++++++++
 tb/tb_syn_fifo_lvl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky error flags,
// synchronous flush and a choice of fall-through or registered read data.
module syn_fifo_lvl #(
   parameter int DEP   = 8,
   parameter int DWID  = 16,
   parameter int AF_TH = 6,
   parameter int AE_TH = 2,
   parameter int FWFT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  wr_i,
   input  logic [DWID-1:0]       wdata,
   input  logic                  rd_i,
   output logic [DWID-1:0]       rdata,
   output logic                  rvalid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  afull_o,
   output logic                  aempty_o,
   output logic [$clog2(DEP):0]  count_o,
   output logic                  ovf_o,
   output logic                  udf_o
);

   localparam int AW = $clog2(DEP);
   localparam int PW = AW + 1;

   logic [DWID-1:0] mem_q [DEP];
   logic [PW-1:0]   wrptr_q, wrptr_d;
   logic [PW-1:0]   rdptr_q, rdptr_d;
   logic            ovf_q, ovf_d;
   logic            udf_q, udf_d;
   logic            wr_acc, rd_acc;

   // Pointers carry a wrap bit, so their difference is the fill level directly.
   assign count_o  = wrptr_q - rdptr_q;
   assign full_o   = (count_o == PW'(DEP));
   assign empty_o  = (wrptr_q == rdptr_q);
   assign afull_o  = (count_o >= PW'(AF_TH));
   assign aempty_o = (count_o <= PW'(AE_TH));
   assign ovf_o    = ovf_q;
   assign udf_o    = udf_q;

   always_comb begin
      wr_acc  = wr_i & ~full_o & ~flush_i;
      rd_acc  = rd_i & ~empty_o & ~flush_i;
      wrptr_d = wrptr_q + PW'(wr_acc);
      rdptr_d = rdptr_q + PW'(rd_acc);
      ovf_d   = ovf_q | (wr_i & full_o);
      udf_d   = udf_q | (rd_i & empty_o);
      if (flush_i) begin
         wrptr_d = '0;
         rdptr_d = '0;
         ovf_d   = 1'b0;
         udf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is not reset; the rst term stops an edge during reset from landing a write.
   always_ff @(posedge clk) begin
      if (rst && wr_acc)
         mem_q[wrptr_q[AW-1:0]] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Masking while empty keeps rdata at zero after reset without a data register.
         assign rdata    = empty_o ? '0 : mem_q[rdptr_q[AW-1:0]];
         assign rvalid_o = ~empty_o;
      end else begin : g_reg
         logic [DWID-1:0] rdata_q, rdata_d;
         logic            rvalid_q, rvalid_d;

         always_comb begin
            rdata_d  = rd_acc ? mem_q[rdptr_q[AW-1:0]] : rdata_q;
            rvalid_d = rd_acc;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rdata_q  <= rdata_d;
               rvalid_q <= rvalid_d;
            end
         end

         assign rdata    = rdata_q;
         assign rvalid_o = rvalid_q;
      end
   endgenerate

endmodule

// File: tb/tb_syn_fifo_lvl.sv
// Directed bench: a fall-through instance carries most steps, a registered-read
// instance covers the one-cycle read latency.
module tb_syn_fifo_lvl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        flush_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
   logic [15:0] wdata_a = '0;
   logic [15:0] rdata_a;
   logic        rvalid_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
   logic [3:0]  count_a;

   logic        flush_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
   logic [15:0] wdata_b = '0;
   logic [15:0] rdata_b;
   logic        rvalid_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
   logic [3:0]  count_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   syn_fifo_lvl #(.DEP(8), .DWID(16), .AF_TH(6), .AE_TH(2), .FWFT(1)) u_a (
      .clk(clk), .rst(rst), .flush_i(flush_a), .wr_i(wr_a), .wdata(wdata_a),
      .rd_i(rd_a), .rdata(rdata_a), .rvalid_o(rvalid_a), .full_o(full_a),
      .empty_o(empty_a), .afull_o(afull_a), .aempty_o(aempty_a),
      .count_o(count_a), .ovf_o(ovf_a), .udf_o(udf_a)
   );

   syn_fifo_lvl #(.DEP(8), .DWID(16), .AF_TH(6), .AE_TH(2), .FWFT(0)) u_b (
      .clk(clk), .rst(rst), .flush_i(flush_b), .wr_i(wr_b), .wdata(wdata_b),
      .rd_i(rd_b), .rdata(rdata_b), .rvalid_o(rvalid_b), .full_o(full_b),
      .empty_o(empty_b), .afull_o(afull_b), .aempty_o(aempty_b),
      .count_o(count_b), .ovf_o(ovf_b), .udf_o(udf_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, ".count"},  32'(count_a),  0);
      chk({tag, ".empty"},  32'(empty_a),  1);
      chk({tag, ".aempty"}, 32'(aempty_a), 1);
      chk({tag, ".full"},   32'(full_a),   0);
      chk({tag, ".afull"},  32'(afull_a),  0);
      chk({tag, ".ovf"},    32'(ovf_a),    0);
      chk({tag, ".udf"},    32'(udf_a),    0);
      chk({tag, ".rvalid"}, 32'(rvalid_a), 0);
      chk({tag, ".rdata"},  32'(rdata_a),  0);
   endtask

   initial begin
      #3;
      chk_reset_a("rst_a");
      chk("rst_b.rvalid", 32'(rvalid_b), 0);
      chk("rst_b.rdata",  32'(rdata_b),  0);
      chk("rst_b.empty",  32'(empty_b),  1);
      #9 rst = 1'b1;
      step();

      // Registered read: data and strobe one cycle after rd_i
      wr_b = 1'b1; wdata_b = 16'hA5A5;
      step();
      wr_b = 1'b0;
      chk("b.wr.rvalid", 32'(rvalid_b), 0);
      chk("b.wr.count",  32'(count_b),  1);
      rd_b = 1'b1;
      step();
      rd_b = 1'b0;
      chk("b.rd.rvalid", 32'(rvalid_b), 1);
      chk("b.rd.rdata",  32'(rdata_b),  16'hA5A5);
      step();
      chk("b.next.rvalid", 32'(rvalid_b), 0);
      chk("b.next.rdata",  32'(rdata_b),  16'hA5A5);
      chk("b.next.empty",  32'(empty_b),  1);

      // Fill to full, then overflow
      for (int i = 1; i <= 8; i++) begin
         wr_a = 1'b1; wdata_a = 16'(i);
         step();
         chk("fill.count",  32'(count_a),  32'(i));
         chk("fill.afull",  32'(afull_a),  (i >= 6) ? 1 : 0);
         chk("fill.full",   32'(full_a),   (i == 8) ? 1 : 0);
         chk("fill.rdata",  32'(rdata_a),  1);
         chk("fill.rvalid", 32'(rvalid_a), 1);
      end
      wdata_a = 16'h0099;
      step();
      wr_a = 1'b0;
      chk("ovf.flag",  32'(ovf_a),   1);
      chk("ovf.count", 32'(count_a), 8);

      // Drain in order, then underflow
      for (int i = 1; i <= 8; i++) begin
         chk("drain.rdata", 32'(rdata_a), 32'(i));
         rd_a = 1'b1;
         step();
         chk("drain.count",  32'(count_a),  32'(8 - i));
         chk("drain.aempty", 32'(aempty_a), (8 - i <= 2) ? 1 : 0);
         chk("drain.empty",  32'(empty_a),  (i == 8) ? 1 : 0);
      end
      step();
      rd_a = 1'b0;
      chk("udf.flag",  32'(udf_a),   1);
      chk("udf.count", 32'(count_a), 0);

      flush_a = 1'b1;
      step();
      flush_a = 1'b0;
      chk("flush1.ovf", 32'(ovf_a), 0);
      chk("flush1.udf", 32'(udf_a), 0);

      // Empty with wr+rd: write taken, read rejected
      wr_a = 1'b1; rd_a = 1'b1; wdata_a = 16'h0100;
      step();
      rd_a = 1'b0;
      chk("emptywr.count", 32'(count_a), 1);
      chk("emptywr.udf",   32'(udf_a),   1);
      chk("emptywr.rdata", 32'(rdata_a), 16'h0100);
      for (int i = 1; i <= 2; i++) begin
         wdata_a = 16'(16'h0100 + i);
         step();
      end
      chk("pre3.count", 32'(count_a), 3);

      // 20 cycles of concurrent wr+rd at count 3, wrapping the storage
      rd_a = 1'b1;
      for (int k = 0; k < 20; k++) begin
         wdata_a = 16'(16'h0200 + k);
         chk("stream.rdata", 32'(rdata_a), (k < 3) ? 32'(16'h0100 + k) : 32'(16'h0200 + k - 3));
         step();
         chk("stream.count", 32'(count_a), 3);
      end
      rd_a = 1'b0;

      // Top off to full, then wr+rd while full: read taken, write rejected
      for (int i = 0; i < 5; i++) begin
         wdata_a = 16'(16'h0300 + i);
         step();
      end
      chk("full2.full", 32'(full_a), 1);
      rd_a = 1'b1; wdata_a = 16'h03FF;
      step();
      wr_a = 1'b0; rd_a = 1'b0;
      chk("fullwr.count", 32'(count_a), 7);
      chk("fullwr.ovf",   32'(ovf_a),   1);
      chk("fullwr.rdata", 32'(rdata_a), 16'h0212);

      begin
         logic [15:0] exp7 [7] = '{16'h0212, 16'h0213, 16'h0300, 16'h0301,
                                   16'h0302, 16'h0303, 16'h0304};
         rd_a = 1'b1;
         for (int i = 0; i < 7; i++) begin
            chk("drain2.rdata", 32'(rdata_a), 32'(exp7[i]));
            step();
         end
         rd_a = 1'b0;
         chk("drain2.empty", 32'(empty_a), 1);
      end

      // Count 5 with ovf set, then flush together with a write
      wr_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wdata_a = 16'(16'h0400 + i);
         step();
      end
      chk("pre6.count", 32'(count_a), 5);
      chk("pre6.ovf",   32'(ovf_a),   1);
      flush_a = 1'b1; wdata_a = 16'h04FF;
      step();
      flush_a = 1'b0;
      chk("flush2.count", 32'(count_a), 0);
      chk("flush2.empty", 32'(empty_a), 1);
      chk("flush2.ovf",   32'(ovf_a),   0);

      // Write burst, then asynchronous reset between edges
      for (int i = 0; i < 3; i++) begin
         wdata_a = 16'(16'h0500 + i);
         step();
      end
      chk("burst.count", 32'(count_a), 3);
      #2 rst = 1'b0;
      #1;
      chk_reset_a("arst");
      #3;
      chk("arst.hold.count", 32'(count_a), 0);
      wr_a = 1'b0;
      rst = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
